// File: rtl/pci_target_burst.sv
// Memory-backed PCI target with burst reads/writes, byte enables and wait states.
// Define PCI_TARGET_DISCONNECT_EN to disconnect with data at the top word instead of wrapping.
module pci_target_burst #(
    parameter int          ADDR_BITS   = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [31:0] AD,
    input  logic [3:0]  CBE,
    input  logic        FRAME,
    input  logic        IRDY,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_WAIT,
        S_DATA,
        S_TURNOFF,
`ifdef PCI_TARGET_DISCONNECT_EN
        S_DISC,
`endif
        S_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   ad_oe_q, ad_oe_d;
    logic                   is_read_q, is_read_d;

    logic [31:0]            mem [DEPTH];

    logic                   hit;
    logic                   rd_cmd;
    logic                   wr_cmd;
    logic                   xfer;
    logic                   wr_en;
    state_t                 phase_next;

    always_comb begin
        hit        = (AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
        rd_cmd     = (CBE == 4'b0010) || (CBE == 4'b0110);
        wr_cmd     = (CBE == 4'b0011) || (CBE == 4'b0111);
        xfer       = (state_q == S_DATA) && !IRDY;
        wr_en      = xfer && !is_read_q && !RST;
        phase_next = (WS == 4'd0) ? S_DATA : S_WAIT;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ad_oe_d   = ad_oe_q;
        is_read_d = is_read_q;

        case (state_q)
            S_IDLE: begin
                if (!FRAME) begin
                    ptr_d = AD[ADDR_BITS+1:2];
                    cnt_d = WS;
                    if (hit && wr_cmd) begin
                        is_read_d = 1'b0;
                        state_d   = phase_next;
                    end else if (hit && rd_cmd) begin
                        is_read_d = 1'b1;
                        state_d   = S_TURN;
                    end else begin
                        state_d   = S_BUSY;
                    end
                end
            end
            S_TURN: begin
                ad_oe_d = 1'b1;
                cnt_d   = WS;
                state_d = phase_next;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    cnt_d = WS;
`ifdef PCI_TARGET_DISCONNECT_EN
                    // Top word ends the burst: the pointer never wraps in this build.
                    if (&ptr_q) begin
                        if (FRAME) begin
                            ad_oe_d = 1'b0;
                            state_d = S_TURNOFF;
                        end else begin
                            state_d = S_DISC;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        if (FRAME) begin
                            ad_oe_d = 1'b0;
                            state_d = S_TURNOFF;
                        end else begin
                            state_d = phase_next;
                        end
                    end
`else
                    ptr_d = ptr_q + 1'b1;
                    if (FRAME) begin
                        ad_oe_d = 1'b0;
                        state_d = S_TURNOFF;
                    end else begin
                        state_d = phase_next;
                    end
`endif
                end
            end
`ifdef PCI_TARGET_DISCONNECT_EN
            S_DISC: begin
                if (FRAME) begin
                    ad_oe_d = 1'b0;
                    state_d = S_TURNOFF;
                end
            end
`endif
            S_TURNOFF: begin
                ad_oe_d = 1'b0;
                state_d = S_IDLE;
            end
            S_BUSY: begin
                if (FRAME && IRDY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= 4'd0;
            ad_oe_q   <= 1'b0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ad_oe_q   <= ad_oe_d;
            is_read_q <= is_read_d;
        end
    end

    // Storage is deliberately left out of reset so it survives a bus reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (!CBE[i]) begin
                    mem[ptr_q][8*i +: 8] <= AD[8*i +: 8];
                end
            end
        end
    end

    assign AD = ad_oe_q ? mem[ptr_q] : {32{1'bz}};

    always_comb begin
        TRDY = (state_q != S_DATA);
`ifdef PCI_TARGET_DISCONNECT_EN
        DEVSEL = !((state_q == S_TURN) || (state_q == S_WAIT) ||
                   (state_q == S_DATA) || (state_q == S_DISC));
        STOP   = !(((state_q == S_DATA) && (&ptr_q)) || (state_q == S_DISC));
`else
        DEVSEL = !((state_q == S_TURN) || (state_q == S_WAIT) || (state_q == S_DATA));
        STOP   = 1'b1;
`endif
    end

endmodule

// File: tb/tb_pci_target_burst.sv
// Scoreboard bench for pci_target_burst: two targets share one bus (base 0/no waits, base 0x100/two waits).
// Expectations follow PCI_TARGET_DISCONNECT_EN when it is defined.
module tb_pci_target_burst;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  cbe;
    logic        frame_n;
    logic        irdy_n;
    logic [31:0] tb_ad;
    logic        tb_ad_en;
    wire  [31:0] ad_bus;

    logic        trdy0, devsel0, stop0;
    logic        trdy1, devsel1, stop1;
    logic [1:0]  trdy_v, devsel_v, stop_v;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic        stop_n;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] buf_data [8];
    logic [3:0]  buf_be   [8];

    assign ad_bus   = tb_ad_en ? tb_ad : {32{1'bz}};
    assign trdy_v   = {trdy1, trdy0};
    assign devsel_v = {devsel1, devsel0};
    assign stop_v   = {stop1, stop0};

    always #5 CLK = ~CLK;

    pci_target_burst #(.ADDR_BITS(4), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .RST(RST), .AD(ad_bus), .CBE(cbe), .FRAME(frame_n), .IRDY(irdy_n),
        .TRDY(trdy0), .DEVSEL(devsel0), .STOP(stop0)
    );

    pci_target_burst #(.ADDR_BITS(4), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(2)) dut1 (
        .CLK(CLK), .RST(RST), .AD(ad_bus), .CBE(cbe), .FRAME(frame_n), .IRDY(irdy_n),
        .TRDY(trdy1), .DEVSEL(devsel1), .STOP(stop1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic ir, input logic [3:0] c,
                                 input logic [31:0] a, input logic en);
        frame_n  = f;
        irdy_n   = ir;
        cbe      = c;
        tb_ad    = a;
        tb_ad_en = en;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic exp_stop(input int ptr);
`ifdef PCI_TARGET_DISCONNECT_EN
        return (ptr == 15) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    // Pops one expectation per data phase the bus actually completes.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST && (!trdy0 || !trdy1) && !irdy_n) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) begin
                    checkOutput("rd_data", ad_bus, e.data);
                end
                checkOutput("xfer_stop", {31'b0, (!trdy0 ? stop0 : stop1)}, {31'b0, e.stop_n});
            end
        end
    end

    task automatic write_burst(input int sel, input logic [31:0] addr, input logic [3:0] cmd,
                               input int n, input int exp_xfers);
        int   ws;
        int   ptr;
        int   done;
        int   budget;
        logic stopped;
        exp_t e;
        ws      = (sel == 0) ? 0 : 2;
        ptr     = int'(addr[5:2]);
        done    = 0;
        stopped = 1'b0;
        checkOutput("wr_devsel_pre", {31'b0, devsel_v[sel]}, 32'd1);
        applyStimulus(1'b0, 1'b1, cmd, addr, 1'b1);
        tick();
        checkOutput("wr_devsel_addr", {31'b0, devsel_v[sel]}, 32'd0);
        checkOutput("wr_trdy_addr", {31'b0, trdy_v[sel]}, (ws == 0) ? 32'd0 : 32'd1);
        checkOutput("wr_other_devsel", {31'b0, devsel_v[1-sel]}, 32'd1);
        for (int i = 0; i < n; i++) begin
            applyStimulus((i == n - 1), 1'b0, buf_be[i], buf_data[i], 1'b1);
            budget = 0;
            while (trdy_v[sel] && budget < 20) begin
                tick();
                budget++;
            end
            checkOutput("wr_trdy_wait", {31'b0, trdy_v[sel]}, 32'd0);
            if (trdy_v[sel]) break;
            e.is_read = 1'b0;
            e.data    = buf_data[i];
            e.stop_n  = exp_stop(ptr);
            exp_q.push_back(e);
            stopped = !stop_v[sel];
            tick();
            done++;
            ptr = (ptr + 1) % 16;
            if (stopped) break;
        end
        if (stopped && done < n) begin
            checkOutput("disc_trdy", {31'b0, trdy_v[sel]}, 32'd1);
            checkOutput("disc_devsel", {31'b0, devsel_v[sel]}, 32'd0);
            checkOutput("disc_stop", {31'b0, stop_v[sel]}, 32'd0);
            applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
        checkOutput("wr_turnoff_devsel", {31'b0, devsel_v[sel]}, 32'd1);
        checkOutput("wr_xfers", done, exp_xfers);
        tick();
    endtask

    task automatic read_burst(input int sel, input logic [31:0] addr, input logic [3:0] cmd,
                              input int n, input int irdy_wait, input int exp_first, input int exp_gap);
        int   ptr;
        int   cyc;
        int   last;
        int   budget;
        logic stopped;
        exp_t e;
        ptr     = int'(addr[5:2]);
        cyc     = 0;
        last    = 0;
        stopped = 1'b0;
        checkOutput("rd_devsel_pre", {31'b0, devsel_v[sel]}, 32'd1);
        applyStimulus(1'b0, 1'b1, cmd, addr, 1'b1);
        tick();
        checkOutput("rd_turn_devsel", {31'b0, devsel_v[sel]}, 32'd0);
        checkOutput("rd_turn_trdy", {31'b0, trdy_v[sel]}, 32'd1);
        applyStimulus(1'b0, (irdy_wait > 0), 4'h0, 32'h0, 1'b1);
        #1;
        checkOutput("rd_turn_ad_released", ad_bus, 32'h0);
        for (int i = 0; i < n; i++) begin
            applyStimulus((i == n - 1), (i == 0 && irdy_wait > 0), 4'h0, 32'h0, 1'b0);
            budget = 0;
            while (trdy_v[sel] && budget < 20) begin
                tick();
                cyc++;
                budget++;
            end
            checkOutput("rd_trdy_wait", {31'b0, trdy_v[sel]}, 32'd0);
            if (trdy_v[sel]) break;
            if (i == 0 && irdy_wait > 0) begin
                for (int k = 0; k < irdy_wait; k++) begin
                    tick();
                    cyc++;
                    checkOutput("rd_irdy_hold_trdy", {31'b0, trdy_v[sel]}, 32'd0);
                end
                irdy_n = 1'b0;
            end
            e.is_read = 1'b1;
            e.data    = buf_data[i];
            e.stop_n  = exp_stop(ptr);
            exp_q.push_back(e);
            stopped = !stop_v[sel];
            tick();
            cyc++;
            if (i == 0) checkOutput("rd_first_latency", cyc, exp_first);
            else        checkOutput("rd_gap", cyc - last, exp_gap);
            last = cyc;
            ptr  = (ptr + 1) % 16;
            if (stopped && i < n - 1) begin
                applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
                tick();
                break;
            end
        end
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
        tick();
    endtask

    task automatic miss_txn(input logic [31:0] addr, input logic [3:0] cmd);
        applyStimulus(1'b0, 1'b1, cmd, addr, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("miss_devsel_trdy", {28'b0, devsel_v, trdy_v}, 32'hF);
            applyStimulus(1'b0, 1'b0, 4'h0, 32'h1234_5678, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h1234_5678, 1'b1);
        tick();
        checkOutput("miss_last_phase", {28'b0, devsel_v, trdy_v}, 32'hF);
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_outputs", {26'b0, trdy_v, devsel_v, stop_v}, 32'h3F);
        checkOutput("reset_ad_released", ad_bus, 32'h0);
        RST = 1'b0;
        tick();

        // Single write with byte enables over a preloaded word.
        buf_data[0] = 32'h1122_3344; buf_be[0] = 4'b0000;
        write_burst(0, 32'h8, 4'b0111, 1, 1);
        buf_data[0] = 32'hDEAD_BEEF; buf_be[0] = 4'b1100;
        write_burst(0, 32'h8, 4'b0011, 1, 1);
        buf_data[0] = 32'h1122_BEEF;
        read_burst(0, 32'h8, 4'b0110, 1, 0, 2, 1);

        // Wait-state target: 3-word burst write then read from ptr 1.
        buf_data[0] = 32'h1111_0001; buf_be[0] = 4'b0000;
        buf_data[1] = 32'h2222_0002; buf_be[1] = 4'b0000;
        buf_data[2] = 32'h3333_0003; buf_be[2] = 4'b0000;
        write_burst(1, 32'h104, 4'b0111, 3, 3);
        read_burst(1, 32'h104, 4'b0010, 3, 0, 4, 3);

        // Burst of 4, sparse byte write, then read with initiator wait states.
        for (int i = 0; i < 4; i++) begin
            buf_data[i] = 32'hA000_0004 + 32'(i);
            buf_be[i]   = 4'b0000;
        end
        write_burst(0, 32'h10, 4'b0111, 4, 4);
        buf_data[0] = 32'h5566_7788; buf_be[0] = 4'b1010;
        write_burst(0, 32'h18, 4'b0111, 1, 1);
        buf_data[0] = 32'hA000_0005;
        buf_data[1] = 32'hA066_0088;
        read_burst(0, 32'h14, 4'b0110, 2, 2, 4, 1);

        // Misses: outside both windows, unsupported command, just past the second window.
        miss_txn(32'h0000_0800, 4'b0110);
        miss_txn(32'h0000_0008, 4'b0000);
        miss_txn(32'h0000_0140, 4'b0111);
        applyStimulus(1'b1, 1'b1, 4'b0110, 32'h8, 1'b1);
        tick();
        checkOutput("no_frame_no_claim", {30'b0, devsel_v}, 32'h3);

        // Asynchronous reset while a read is driving the bus.
        applyStimulus(1'b0, 1'b1, 4'b0110, 32'h8, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        tick();
        checkOutput("rst_pre_trdy", {31'b0, trdy0}, 32'd0);
        checkOutput("rst_pre_ad", ad_bus, 32'h1122_BEEF);
        RST      = 1'b1;
        tb_ad_en = 1'b1;
        tb_ad    = 32'h0;
        #1;
        checkOutput("rst_mid_outputs", {26'b0, trdy_v, devsel_v, stop_v}, 32'h3F);
        checkOutput("rst_mid_ad_released", ad_bus, 32'h0);
        tick();
        RST = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b1);
        tick();
        buf_data[0] = 32'h1122_BEEF;
        read_burst(0, 32'h8, 4'b0110, 1, 0, 2, 1);

        // Top-of-window burst: wraps, or disconnects with data.
        buf_data[0] = 32'h0000_0A00; buf_be[0] = 4'b0000;
        buf_data[1] = 32'h0000_0A01; buf_be[1] = 4'b0000;
        write_burst(0, 32'h0, 4'b0111, 2, 2);
        buf_data[0] = 32'hF000_000F; buf_be[0] = 4'b0000;
        buf_data[1] = 32'hF000_0000; buf_be[1] = 4'b0000;
        buf_data[2] = 32'hF000_0001; buf_be[2] = 4'b0000;
`ifdef PCI_TARGET_DISCONNECT_EN
        write_burst(0, 32'h3C, 4'b0111, 3, 1);
        buf_data[0] = 32'hF000_000F;
        read_burst(0, 32'h3C, 4'b0110, 1, 0, 2, 1);
        buf_data[0] = 32'h0000_0A00;
        buf_data[1] = 32'h0000_0A01;
        read_burst(0, 32'h0, 4'b0110, 2, 0, 2, 1);
`else
        write_burst(0, 32'h3C, 4'b0111, 3, 3);
        read_burst(0, 32'h3C, 4'b0110, 3, 0, 2, 1);
`endif

        repeat (2) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pci_target_burst.md
# pci_target_burst

Parametrised PCI target that supersedes the fixed single-transfer slave: a memory-backed target with configurable window size, base address and per-phase wait states, supporting multi-word burst reads and writes with per-byte enables. It sits on the shared PCI bus (AD/CBE/FRAME/IRDY) next to the existing slave, claims transactions that hit its window, and drives TRDY/DEVSEL/STOP.

## Interface
Parameters:
- ADDR_BITS, 4: word-address width; window holds DEPTH = 2**ADDR_BITS 32-bit words.
- BASE_ADDR, 32'h0000_0000: window base; only bits [31:ADDR_BITS+2] are compared.
- WAIT_STATES, 0: cycles TRDY stays high before each data phase (0..15).

Ports:
- CLK  input  1  bus clock; all sampling on rising edge.
- RST  input  1  reset; one clock; reset is asynchronous and active-high.
- AD  inout  32  multiplexed address/data; driven only during read data phases.
- CBE  input  4  command in address phase; active-low byte enables in data phases.
- FRAME  input  1  active-low; low = transaction in progress, high with IRDY low = last data phase.
- IRDY  input  1  active-low initiator ready.
- TRDY  output  1  active-low target ready.
- DEVSEL  output  1  active-low device select.
- STOP  output  1  active-low target disconnect (see Configuration).

## Operation
- Commands: 4'b0010/4'b0110 = read, 4'b0011/4'b0111 = write; all others ignored (no claim).
- Hit: AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2] and supported command; word pointer = AD[ADDR_BITS+1:2]; AD[1:0] ignored.
- States: IDLE, TURN (read turnaround), WAIT, DATA, TURNOFF, BUSY (miss; wait for idle bus).
- IDLE: rising edge with FRAME=0 is the address phase; latch pointer and command. Hit+write -> WAIT (or DATA if WAIT_STATES=0). Hit+read -> TURN. Miss -> BUSY.
- TURN: one cycle, DEVSEL low, AD still released; then WAIT/DATA.
- WAIT: counter loaded with WAIT_STATES, decrements per cycle; at 0 -> DATA.
- DATA: TRDY low. Transfer occurs on edge with IRDY=0 and TRDY=0. IRDY high = initiator wait; state holds, TRDY stays low.
- Write transfer: byte i of mem[ptr] updated from AD[8i+7:8i] when CBE[i]=0; others unchanged.
- Read: AD = mem[ptr] (asynchronous array read) whenever AD enable set; enable set from TURN exit until TURNOFF entry.
- After each transfer: ptr = ptr+1 modulo DEPTH; counter reloaded; FRAME=1 at that edge -> TURNOFF, else WAIT/DATA.
- TURNOFF: one cycle, TRDY/DEVSEL/STOP high, AD released; -> IDLE.
- BUSY: outputs high; -> IDLE on edge with FRAME=1 and IRDY=1.
- Memory contents not reset.

## Timing
- Reset values: TRDY=1, DEVSEL=1, STOP=1, AD high-Z, state IDLE, counter 0. Reset mid-burst releases all outputs immediately (async); no partial-byte write on the reset edge.
- Write, WAIT_STATES=0: address edge A; DEVSEL and TRDY low after A; first data captured at A+1 if IRDY=0.
- Read, WAIT_STATES=0: DEVSEL low after A; AD driven and TRDY low after A+1; first data taken at A+2.
- WAIT_STATES=N adds N cycles of TRDY high before every data phase (including the first).
- Back-to-back bursts: new address phase accepted no earlier than the edge after TURNOFF.
- Pointer wrap: transfer at ptr=DEPTH-1 continues at ptr=0 (without macro).
- Simultaneous FRAME=1 at address edge is not an address phase; stays IDLE.

## Configuration
- PCI_TARGET_DISCONNECT_EN defined: at DATA with ptr=DEPTH-1, STOP asserted low together with TRDY (disconnect with data); after that transfer TRDY goes high, STOP and DEVSEL held low until FRAME sampled high, then TURNOFF. No wrap ever occurs.
- Undefined: STOP tied high permanently; pointer wraps as above.

## Test plan
- Reset: RST=1 mid-read burst -> TRDY/DEVSEL/STOP=1 and AD=Z in same cycle; after release state IDLE.
- Single write, WAIT_STATES=0, BASE_ADDR=0: AD=32'h8, CBE=0011, then data 32'hDEADBEEF with CBE=4'b1100, FRAME=1, IRDY=0 -> mem[2] low 16 bits = 16'hBEEF, upper bytes unchanged; DEVSEL low exactly one cycle after address edge.
- Burst read of 3 words at ptr 1, WAIT_STATES=2 -> TRDY low once per 3 cycles, AD returns mem[1], mem[2], mem[3]; TURN cycle shows AD=Z with DEVSEL low.
- IRDY wait: initiator holds IRDY high 2 cycles during DATA -> TRDY stays low, ptr unchanged, data transferred on first edge with IRDY=0.
- Miss: address outside window, or CBE=4'b0000 -> DEVSEL/TRDY stay high for whole transaction; target back in IDLE after FRAME=1, IRDY=1.
- Boundary, ADDR_BITS=4: 3-word write starting at ptr 15 -> without macro writes mem[15], mem[0], mem[1]; with PCI_TARGET_DISCONNECT_EN, STOP low at the ptr-15 transfer, only mem[15] written.
